counter_frame_tx: RTL and testbench

Parametrised frame-generating counter that drives the UART transmitter. Each frame snapshots a WIDTH-bit counter, advances it by STEP (up or down, wrapping or saturating), and sends a byte frame to the UART TX over a DV/Done handshake: optional sync byte, data bytes MSB-first, optional XOR checksum. It replaces the single-byte free-running test counter as the stimulus source for fault-injection runs, where the header and checksum let the host detect corrupted frames.

---
 rtl/counter_frame_pkg.sv | 21 ++
 rtl/counter_step_unit.sv | 35 +++
 rtl/counter_frame_tx.sv | 149 ++++++++++++++
 tb/tb_counter_frame_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_frame_pkg.sv
// Shared definitions for the frame-generating counter: FSM encoding, default sync byte
// and the byte-count helper used to size the snapshot register.
package counter_frame_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_SEND = S_SEND,
        ST_WAIT = S_WAIT
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/counter_step_unit.sv
// Combinational next-count: adds or subtracts STEP with one extra bit so the
// carry/borrow can drive either modulo wrap or saturation.
module counter_step_unit
    import counter_frame_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned STEP     = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH:0] STEP_X = {1'b0, WIDTH'(STEP)};

    logic [WIDTH:0] up_w;
    logic [WIDTH:0] dn_w;

    assign up_w = {1'b0, count_i} + STEP_X;
    assign dn_w = {1'b0, count_i} - STEP_X;

    always_comb begin
        next_o = dir_i ? up_w[WIDTH-1:0] : dn_w[WIDTH-1:0];
        // Top bit is the carry on the way up and the borrow on the way down.
        if (SATURATE) begin
            if (dir_i && up_w[WIDTH]) begin
                next_o = '1;
            end else if (!dir_i && dn_w[WIDTH]) begin
                next_o = '0;
            end
        end
    end

endmodule

// File: rtl/counter_frame_tx.sv
// Frame-generating counter: snapshots the count, advances it, and streams
// [header] data-MSB-first [xor checksum] to a UART TX over a DV/Done handshake.
module counter_frame_tx
    import counter_frame_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned STEP      = 1,
    parameter bit          SATURATE  = 1'b0,
    parameter bit          HEADER_EN = 1'b1,
    parameter logic [7:0]  HEADER    = DEFAULT_HEADER,
    parameter bit          CHK_EN    = 1'b1
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_En,
    input  logic             i_Dir,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Load_Val,
    input  logic             i_Tx_Active,
    input  logic             i_Tx_Done,
    output logic             o_Tx_DV,
    output logic [7:0]       o_Tx_Byte,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_Busy,
    output logic             o_Frame_Done,
    output logic [1:0]       o_Dbg_State
);

    // Handshake: o_Tx_DV is a one-cycle pulse issued only when i_Tx_Active was low at
    // the issuing edge; the byte is then owned by the UART until its i_Tx_Done pulse.
    localparam int NBYTES = nbytes(WIDTH);
    localparam int SNAP_W = 8 * NBYTES;
    localparam int NFRAME = NBYTES + int'(HEADER_EN) + int'(CHK_EN);
    localparam int IDX_W  = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFRAME - 1);

    state_t              state_q;
    logic [WIDTH-1:0]    count_q;
    logic [WIDTH-1:0]    count_d;
    logic [WIDTH-1:0]    step_next;
    logic [SNAP_W-1:0]   snap_q;
    logic [IDX_W-1:0]    idx_q;
    logic [7:0]          chk_q;
    logic [7:0]          tx_byte_q;
    logic                tx_dv_q;
    logic                frame_done_q;
    logic [7:0]          cur_byte;
    logic                is_hdr;
    logic                is_chk;
    logic                snap_go;

    counter_step_unit #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_step (
        .count_i (count_q),
        .dir_i   (i_Dir),
        .next_o  (step_next)
    );

    assign snap_go = (state_q == ST_IDLE) && i_En && !i_Tx_Active;

    // A load wins over the advance, but the snapshot still captures the old count.
    always_comb begin
        count_d = count_q;
        if (i_Load) begin
            count_d = i_Load_Val;
        end else if (snap_go) begin
            count_d = step_next;
        end
    end

    always_comb begin
        is_hdr   = HEADER_EN && (idx_q == '0);
        is_chk   = CHK_EN && (idx_q == LAST_IDX);
        cur_byte = snap_q[SNAP_W-1 -: 8];
        if (is_hdr) begin
            cur_byte = HEADER;
        end else if (is_chk) begin
            cur_byte = chk_q;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            idx_q        <= '0;
            chk_q        <= '0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            tx_dv_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (snap_go) begin
                        snap_q  <= SNAP_W'(count_q);
                        chk_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!i_Tx_Active) begin
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= cur_byte;
                        // Data bytes leave from the top of the snapshot and feed the checksum.
                        if (!is_hdr && !is_chk) begin
                            chk_q  <= chk_q ^ cur_byte;
                            snap_q <= snap_q << 8;
                        end
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_Tx_Done) begin
                        if (idx_q == LAST_IDX) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_SEND;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Tx_DV      = tx_dv_q;
    assign o_Tx_Byte    = tx_byte_q;
    assign o_Count      = count_q;
    assign o_Busy       = (state_q != ST_IDLE);
    assign o_Frame_Done = frame_done_q;
    assign o_Dbg_State  = state_q;

endmodule

// File: tb/tb_counter_frame_tx.sv
// Directed bench for counter_frame_tx: four parameterisations driven by one linear
// sequence, with a simple UART responder raising Done ten cycles after each DV.
module tb_counter_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dir = 1'b1;
    logic        load = 1'b0;
    logic [11:0] load_val = '0;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic        en8 = 1'b0, en12 = 1'b0, en_s0 = 1'b0, en_s1 = 1'b0;

    logic        dv8, dv12, dv_s0, dv_s1;
    logic [7:0]  byte8, byte12, byte_s0, byte_s1;
    logic [7:0]  count8, count_s0, count_s1;
    logic [11:0] count12;
    logic        busy8, busy12, busy_s0, busy_s1;
    logic        fd8, fd12, fd_s0, fd_s1;
    logic [1:0]  st8, st12, st_s0, st_s1;

    int          sel = 0;
    logic        sel_dv;
    logic [7:0]  sel_byte;
    logic        prev_dv = 1'b0;
    int          viol = 0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    counter_frame_tx #(.WIDTH(8)) u8 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_En(en8), .i_Dir(dir), .i_Load(load),
        .i_Load_Val(load_val[7:0]), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Tx_DV(dv8), .o_Tx_Byte(byte8), .o_Count(count8), .o_Busy(busy8),
        .o_Frame_Done(fd8), .o_Dbg_State(st8)
    );

    counter_frame_tx #(.WIDTH(12), .HEADER_EN(1'b0)) u12 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_En(en12), .i_Dir(dir), .i_Load(load),
        .i_Load_Val(load_val), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Tx_DV(dv12), .o_Tx_Byte(byte12), .o_Count(count12), .o_Busy(busy12),
        .o_Frame_Done(fd12), .o_Dbg_State(st12)
    );

    counter_frame_tx #(.WIDTH(8), .STEP(3), .SATURATE(1'b0)) u_s0 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_En(en_s0), .i_Dir(dir), .i_Load(load),
        .i_Load_Val(load_val[7:0]), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Tx_DV(dv_s0), .o_Tx_Byte(byte_s0), .o_Count(count_s0), .o_Busy(busy_s0),
        .o_Frame_Done(fd_s0), .o_Dbg_State(st_s0)
    );

    counter_frame_tx #(.WIDTH(8), .STEP(3), .SATURATE(1'b1)) u_s1 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_En(en_s1), .i_Dir(dir), .i_Load(load),
        .i_Load_Val(load_val[7:0]), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Tx_DV(dv_s1), .o_Tx_Byte(byte_s1), .o_Count(count_s1), .o_Busy(busy_s1),
        .o_Frame_Done(fd_s1), .o_Dbg_State(st_s1)
    );

    always_comb begin
        sel_dv   = dv8;
        sel_byte = byte8;
        if (sel == 1) begin
            sel_dv   = dv12;
            sel_byte = byte12;
        end
    end

    // DV must never repeat on back-to-back cycles nor coincide with Active.
    always @(negedge clk) begin
        if (sel_dv && (tx_active || prev_dv)) viol <= viol + 1;
        prev_dv <= sel_dv;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        en8 = 0; en12 = 0; en_s0 = 0; en_s1 = 0;
        load = 0; tx_active = 0; tx_done = 0; dir = 1;
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
    endtask

    task automatic do_load(input logic [11:0] v);
        load_val = v;
        load = 1;
        tick();
        load = 0;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int n;
        logic [7:0] b;
        n = 0;
        while (sel_dv !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_dv_seen"}, 32'(n < 300), 32'd1);
        b = sel_byte;
        chk(tag, 32'(b), 32'(exp));
        tick();
        chk({tag, "_dv_single"}, 32'(sel_dv), 32'd0);
        tx_active = 1;
        repeat (9) tick();
        tx_done = 1;
        tick();
        tx_done = 0;
        tx_active = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int dv_seen;

        // Reset values while reset is held.
        #3;
        chk("rst_count", 32'(count8), 32'h0);
        chk("rst_dv", 32'(dv8), 32'h0);
        chk("rst_byte", 32'(byte8), 32'h0);
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_fd", 32'(fd8), 32'h0);
        do_reset();

        // WIDTH=8 defaults from 0x3C.
        sel = 0;
        do_load(12'h03C);
        en8 = 1; tick(); en8 = 0;
        chk("t1_count", 32'(count8), 32'h3D);
        chk("t1_busy", 32'(busy8), 32'h1);
        expect_byte("t1_b0", 8'hA5);
        expect_byte("t1_b1", 8'h3C);
        expect_byte("t1_b2", 8'h3C);
        chk("t1_fd_hi", 32'(fd8), 32'h1);
        tick();
        chk("t1_fd_lo", 32'(fd8), 32'h0);
        chk("t1_idle", 32'(busy8), 32'h0);

        // WIDTH=12 without header.
        do_reset();
        sel = 1;
        do_load(12'h0FF);
        en12 = 1; tick(); en12 = 0;
        chk("t2_count", 32'(count12), 32'h100);
        expect_byte("t2_b0", 8'h00);
        expect_byte("t2_b1", 8'hFF);
        expect_byte("t2_b2", 8'hFF);
        chk("t2_fd", 32'(fd12), 32'h1);

        // STEP=3 wrap versus saturate, both directions.
        do_reset();
        sel = 0;
        do_load(12'h0FE);
        dir = 1;
        en_s0 = 1; en_s1 = 1; tick(); en_s0 = 0; en_s1 = 0;
        chk("t3_up_wrap", 32'(count_s0), 32'h01);
        chk("t3_up_sat", 32'(count_s1), 32'hFF);
        do_reset();
        do_load(12'h001);
        dir = 0;
        en_s0 = 1; en_s1 = 1; tick(); en_s0 = 0; en_s1 = 0;
        chk("t3_dn_sat", 32'(count_s1), 32'h00);
        chk("t3_dn_wrap", 32'(count_s0), 32'hFE);

        // Active held high after the snapshot blocks DV until it falls.
        do_reset();
        en8 = 1; tick(); en8 = 0;
        tx_active = 1;
        dv_seen = 0;
        repeat (50) begin
            tick();
            if (dv8) dv_seen++;
        end
        chk("t4_no_dv_active", 32'(dv_seen), 32'd0);
        tx_active = 0;
        tick();
        chk("t4_dv_after", 32'(dv8), 32'h1);
        chk("t4_hdr", 32'(byte8), 32'hA5);
        tick();
        chk("t4_dv_pulse", 32'(dv8), 32'h0);

        // Reset during WAIT of the second byte, then a fresh frame from 0.
        do_reset();
        do_load(12'h022);
        en8 = 1; tick(); en8 = 0;
        expect_byte("t5_b0", 8'hA5);
        tick();
        chk("t5_b1_dv", 32'(dv8), 32'h1);
        chk("t5_b1", 32'(byte8), 32'h22);
        tick();
        tx_active = 1;
        repeat (3) tick();
        rst_n = 0;
        #1;
        chk("t5_rst_count", 32'(count8), 32'h0);
        chk("t5_rst_dv", 32'(dv8), 32'h0);
        chk("t5_rst_byte", 32'(byte8), 32'h0);
        chk("t5_rst_busy", 32'(busy8), 32'h0);
        chk("t5_rst_fd", 32'(fd8), 32'h0);
        rst_n = 1;
        tx_active = 0;
        dv_seen = 0;
        repeat (5) begin
            tick();
            if (dv8) dv_seen++;
        end
        chk("t5_quiet", 32'(dv_seen), 32'd0);
        en8 = 1; tick(); en8 = 0;
        expect_byte("t5_n0", 8'hA5);
        expect_byte("t5_n1", 8'h00);
        expect_byte("t5_n2", 8'h00);
        chk("t5_count", 32'(count8), 32'h01);

        // Load in the snapshot cycle.
        do_reset();
        do_load(12'h010);
        load_val = 12'h080;
        load = 1; en8 = 1;
        tick();
        load = 0; en8 = 0;
        chk("t6_count_load", 32'(count8), 32'h80);
        expect_byte("t6_b0", 8'hA5);
        expect_byte("t6_b1", 8'h10);
        expect_byte("t6_b2", 8'h10);
        chk("t6_count_after", 32'(count8), 32'h80);

        // En held high chains frames; dropping it mid-frame does not abort.
        tick();
        en8 = 1;
        tick();
        chk("t7_count1", 32'(count8), 32'h81);
        expect_byte("t7_a0", 8'hA5);
        expect_byte("t7_a1", 8'h80);
        expect_byte("t7_a2", 8'h80);
        chk("t7_fd", 32'(fd8), 32'h1);
        chk("t7_fd_idle", 32'(busy8), 32'h0);
        tick();
        chk("t7_rearm_busy", 32'(busy8), 32'h1);
        chk("t7_count2", 32'(count8), 32'h82);
        en8 = 0;
        expect_byte("t7_b0", 8'hA5);
        expect_byte("t7_b1", 8'h81);
        expect_byte("t7_b2", 8'h81);
        chk("t7_fd2", 32'(fd8), 32'h1);
        tick();
        chk("t7_stay_idle", 32'(busy8), 32'h0);
        chk("t7_count_final", 32'(count8), 32'h82);

        chk("dv_protocol", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
